// File: rtl/wb_exmem_ctrl_if.sv
// Wishbone classic bus bundle between the management-SoC wrapper (master)
// and the external-memory window controller (slave).
interface wb_exmem_ctrl_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_exmem_ctrl.sv
// Wishbone classic slave for the external-memory window: decodes the window,
// drives a fixed-latency single-port BRAM and acks after DELAYS wait cycles.
module wb_exmem_ctrl #(
  parameter logic [7:0] BASE_HI = 8'h38,
  parameter int         ADDR_W  = 10,
  parameter int         DELAYS  = 10
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  wb_exmem_ctrl_if.slave    wbs,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_wdata,
  input  logic [31:0]       bram_rdata,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  // Handshake: a request is taken when cyc & stb & window-hit are seen in IDLE;
  // ack is a single-cycle pulse, and dropping cyc during the wait aborts the
  // access without an ack. The master must hold cyc/stb until ack (classic).
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [7:0]  counter;
  logic        we_l;
  logic        ack_q;
  logic [31:0] dat_q;
  logic        hit;
  logic        accept;
  logic        finish;
  logic        abort;

  // Address bits above the BRAM depth alias; the byte offset is not used.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{wbs.wbs_adr_i[23:ADDR_W+2], wbs.wbs_adr_i[1:0]};

  assign hit = wbs.wbs_cyc_i & wbs.wbs_stb_i & (wbs.wbs_adr_i[31:24] == BASE_HI);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    case (state)
      S_IDLE: begin
        if (hit) begin
          accept     = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!wbs.wbs_cyc_i) begin
          abort      = 1'b1;
          state_next = S_IDLE;
        end else if (counter == 8'd1) begin
          finish     = 1'b1;
          state_next = S_ACK;
        end
      end
      S_ACK:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      counter    <= '0;
      we_l       <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      bram_en    <= 1'b0;
      bram_we    <= '0;
      bram_addr  <= '0;
      bram_wdata <= '0;
    end else begin
      ack_q   <= finish;
      // Write strobe lives only in the first WAIT cycle.
      bram_we <= '0;
      if (accept) begin
        bram_addr  <= wbs.wbs_adr_i[ADDR_W+1:2];
        bram_wdata <= wbs.wbs_dat_i;
        we_l       <= wbs.wbs_we_i;
        bram_we    <= wbs.wbs_we_i ? wbs.wbs_sel_i : 4'b0000;
        bram_en    <= 1'b1;
        counter    <= 8'(DELAYS);
      end else if (finish) begin
        bram_en <= 1'b0;
        counter <= '0;
        if (!we_l) dat_q <= bram_rdata;
      end else if (abort) begin
        bram_en <= 1'b0;
        counter <= '0;
      end else if (state == S_WAIT) begin
        counter <= counter - 8'd1;
      end
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign busy          = (state != S_IDLE);
  assign state_dbg     = state;

endmodule

// File: tb/tb_wb_exmem_ctrl.sv
// Bench for wb_exmem_ctrl: directed scenarios plus random Wishbone traffic
// compared against a transaction-level memory model.
module tb_wb_exmem_ctrl;
  localparam logic [7:0] BASE_HI = 8'h38;
  localparam int ADDR_W = 10;
  localparam int DELAYS = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_exmem_ctrl_if wbs ();
  logic              bram_en;
  logic [3:0]        bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [31:0]       bram_wdata;
  logic [31:0]       bram_rdata;
  logic              busy;
  logic [1:0]        state_dbg;

  wb_exmem_ctrl #(.BASE_HI(BASE_HI), .ADDR_W(ADDR_W), .DELAYS(DELAYS)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs       (wbs),
    .bram_en   (bram_en),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_wdata(bram_wdata),
    .bram_rdata(bram_rdata),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // BRAM model: read data only valid after DELAYS cycles of stable enable
  logic [31:0] mem [DEPTH];
  int          en_cnt;
  logic        mem_ready = 1'b0;
  int          we_pulses = 0;
  logic [3:0]  last_we_val;

  always @(posedge clk) begin
    if (rst && !mem_ready) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      mem_ready <= 1'b1;
    end
    if (rst) begin
      en_cnt <= 0;
    end else if (bram_en) begin
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
      en_cnt <= en_cnt + 1;
    end else begin
      en_cnt <= 0;
    end
    if (bram_we != 4'b0000) begin
      we_pulses   <= we_pulses + 1;
      last_we_val <= bram_we;
    end
  end

  assign bram_rdata = (bram_en && en_cnt >= DELAYS - 1) ? mem[bram_addr]
                                                        : (32'hBAD0_0000 | 32'(en_cnt));

  // scoreboard: reference memory and expected read data
  logic [31:0] exp_mem [DEPTH];
  logic [31:0] exp_q [$];
  logic [31:0] exp_dat;
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int word_of(input logic [31:0] adr);
    return int'((adr / 4) % DEPTH);
  endfunction

  // driver tasks
  task automatic idle_bus();
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_stb_i = 1'b0;
  endtask

  task automatic drive_req(input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic we);
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_adr_i = adr;
    wbs.wbs_dat_i = dat;
    wbs.wbs_sel_i = sel;
    wbs.wbs_we_i  = we;
  endtask

  task automatic access(input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic we);
    int cnt;
    int idx;
    int p0;
    logic got_ack;
    idx = word_of(adr);
    @(negedge clk);
    p0 = we_pulses;
    drive_req(adr, dat, sel, we);
    cnt = 0;
    got_ack = 1'b0;
    while (!got_ack && cnt < 60) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        check("bram_addr", 32'(bram_addr), 32'(idx));
        check("busy_wait", 32'(busy), 32'd1);
        check("bram_en", 32'(bram_en), 32'd1);
      end
      if (wbs.wbs_ack_o) got_ack = 1'b1;
    end
    check("ack_latency", 32'(cnt), 32'(DELAYS + 1));
    idle_bus();
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) exp_mem[idx][8*b +: 8] = dat[8*b +: 8];
      check("we_pulses", 32'(we_pulses - p0), (sel != 4'b0000) ? 32'd1 : 32'd0);
      if (sel != 4'b0000) check("we_value", 32'(last_we_val), 32'(sel));
    end else begin
      check("we_pulses_rd", 32'(we_pulses - p0), 32'd0);
      exp_q.push_back(exp_mem[idx]);
      exp_dat = exp_q.pop_front();
    end
    check(we ? "dat_hold_wr" : "rd_data", wbs.wbs_dat_o, exp_dat);
    @(negedge clk);
    check("ack_one_cycle", 32'(wbs.wbs_ack_o), 32'd0);
    check("busy_done", 32'(busy), 32'd0);
  endtask

  task automatic non_hit(input logic [31:0] adr, input int cycles);
    logic seen;
    @(negedge clk);
    drive_req(adr, $urandom, 4'hF, 1'($urandom_range(0, 1)));
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (wbs.wbs_ack_o || bram_en || busy) seen = 1'b1;
    end
    check("nonhit_quiet", 32'(seen), 32'd0);
    check("nonhit_dat", wbs.wbs_dat_o, exp_dat);
    idle_bus();
  endtask

  logic [31:0] r_adr;
  logic [7:0]  top;
  int t_ack1, t_ack2, n;
  logic seen_ack;

  initial begin
    idle_bus();
    wbs.wbs_we_i  = 1'b0;
    wbs.wbs_sel_i = 4'h0;
    wbs.wbs_adr_i = '0;
    wbs.wbs_dat_i = '0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    exp_dat = '0;

    repeat (2) @(negedge clk);
    check("rst_ack", 32'(wbs.wbs_ack_o), 32'd0);
    check("rst_dat", wbs.wbs_dat_o, 32'd0);
    check("rst_en_we_busy", {29'd0, bram_en, |bram_we, busy}, 32'd0);
    check("rst_addr_wdata", 32'(bram_addr) | bram_wdata, 32'd0);
    rst = 1'b0;

    // write then read, then byte-lane merge
    access(32'h3800_0004, 32'hDEAD_BEEF, 4'hF, 1'b1);
    access(32'h3800_0004, 32'h0, 4'hF, 1'b0);
    access(32'h3800_0004, 32'h0000_00AA, 4'b0001, 1'b1);
    access(32'h3800_0004, 32'h0, 4'hF, 1'b0);
    check("byte_lane_value", exp_dat, 32'hDEAD_BEAA);

    non_hit(32'h3000_0000, 20);

    // abort: drop cyc after 3 cycles
    @(negedge clk);
    drive_req(32'h3800_0010, 32'h0, 4'hF, 1'b0);
    repeat (3) @(negedge clk);
    idle_bus();
    @(negedge clk);
    check("abort_en", 32'(bram_en), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    seen_ack = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (wbs.wbs_ack_o) seen_ack = 1'b1;
    end
    check("abort_no_ack", 32'(seen_ack), 32'd0);
    check("abort_dat", wbs.wbs_dat_o, exp_dat);

    // aliasing: 0x3800_1004 maps to word 1
    access(32'h3800_1004, 32'h0, 4'hF, 1'b0);

    // back-to-back reads with cyc/stb held across the ack
    access(32'h3800_0020, 32'h1234_5678, 4'hF, 1'b1);
    @(negedge clk);
    drive_req(32'h3800_0004, 32'h0, 4'hF, 1'b0);
    t_ack1 = -1;
    t_ack2 = -1;
    n = 0;
    while (t_ack2 < 0 && n < 100) begin
      @(negedge clk);
      n++;
      if (wbs.wbs_ack_o) begin
        if (t_ack1 < 0) begin
          t_ack1 = n;
          check("b2b_rd1", wbs.wbs_dat_o, exp_mem[1]);
          wbs.wbs_adr_i = 32'h3800_0020;
        end else begin
          t_ack2 = n;
          check("b2b_rd2", wbs.wbs_dat_o, exp_mem[8]);
        end
      end
    end
    idle_bus();
    exp_dat = exp_mem[8];
    check("b2b_first_lat", 32'(t_ack1), 32'(DELAYS + 1));
    check("b2b_gap", 32'(t_ack2 - t_ack1), 32'(DELAYS + 2));
    @(negedge clk);

    // reset in the middle of a read
    @(negedge clk);
    drive_req(32'h3800_0004, 32'h0, 4'hF, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    exp_dat = '0;
    check("midrst_ack_dat", 32'(wbs.wbs_ack_o) | wbs.wbs_dat_o, 32'd0);
    check("midrst_bram", {29'd0, bram_en, |bram_we, busy} | 32'(bram_addr) | bram_wdata, 32'd0);
    idle_bus();
    @(negedge clk);
    rst = 1'b0;
    access(32'h3800_0004, 32'h0, 4'hF, 1'b0);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        top = 8'($urandom_range(0, 255));
        if (top == BASE_HI) top = top + 8'd1;
        non_hit({top, 24'($urandom)}, $urandom_range(3, 8));
      end else begin
        r_adr = {BASE_HI, 12'($urandom), 10'($urandom_range(0, 15)), 2'($urandom)};
        access(r_adr, $urandom, 4'($urandom), 1'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global time bound
  initial begin
    #400000;
    errors++;
    $display("FAIL timeout: got=running exp=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
